// File: rtl/mem_wb_banked.sv
// Banked Wishbone classic slave SRAM.
// NUM_BANKS banks of WORDS_PER_BANK 32-bit words, one R/W port per bank,
// registered read data, optional read wait states, err on unmapped bank.
//
// Handshake: a request is valid when wb_cyc_i & wb_stb_i. The master holds the
// request stable until it sees exactly one of wb_ack_o / wb_err_o for one
// cycle. The request is consumed only in IDLE. In ACK/ERR the bus is ignored,
// so the next request is taken the cycle after the ack/err pulse. Dropping
// wb_cyc_i while a read is waiting abandons it without an ack.
module mem_wb_banked #(
  parameter int NUM_BANKS      = 2,
  parameter int WORDS_PER_BANK = 512,
  parameter int READ_WAIT      = 0,
  // Reserved and held at 0: address bits above the bank field are ignored.
  parameter int BASE_MASK_BITS = 0
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic [31:0] wb_dat_o
);

  localparam int WB = $clog2(WORDS_PER_BANK);
  // A single bank still decodes one bank bit, so bank 1 reads as unmapped.
  localparam int BB = (NUM_BANKS > 2) ? $clog2(NUM_BANKS) : 1;
  localparam logic [BB:0] NB = NUM_BANKS[BB:0];

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    ACK     = 2'd2,
    ERR     = 2'd3
  } state_t;

  state_t      state_q;
  logic [1:0]  wait_q;
  logic [BB-1:0] bank_q;

  // FSM state made visible for checkers and debug.
  logic [1:0]  dbg_state;
  assign dbg_state = state_q;

  logic          valid;
  logic [WB-1:0] word_idx;
  logic [BB-1:0] bank_idx;
  logic          in_range;
  logic          accept;
  logic [NUM_BANKS-1:0] bank_en;
  logic [31:0]   bank_rdata [NUM_BANKS];
  logic [31:0]   rd_mux;

  // Byte-lane bits and bits above the bank field alias onto the same words.
  logic unused_adr;
  assign unused_adr = ^{wb_adr_i[31:WB+BB+2], wb_adr_i[1:0]};

  assign valid    = wb_cyc_i & wb_stb_i;
  assign word_idx = wb_adr_i[WB+1:2];
  assign bank_idx = wb_adr_i[WB+1+BB:WB+2];
  assign in_range = ({1'b0, bank_idx} < NB);
  // Gated by reset so nothing reaches the arrays while reset is held.
  assign accept   = wb_rst_n_i & (state_q == IDLE) & valid & in_range;

  // One-hot chip enable; unselected banks stay idle every cycle.
  always_comb begin
    bank_en = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (accept && (bank_idx == BB'(b))) bank_en[b] = 1'b1;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [31:0] mem [WORDS_PER_BANK];
    logic [31:0] rdata_q;

    // Single-port bank: byte-gated write, or synchronous read into rdata_q.
    always_ff @(posedge wb_clk_i) begin
      if (bank_en[b]) begin
        if (wb_we_i) begin
          for (int l = 0; l < 4; l++) begin
            if (wb_sel_i[l]) mem[word_idx][8*l +: 8] <= wb_dat_i[8*l +: 8];
          end
        end else begin
          rdata_q <= mem[word_idx];
        end
      end
    end

    assign bank_rdata[b] = rdata_q;
  end

  // Return data is chosen by the bank captured at issue, not the live address.
  always_comb begin
    rd_mux = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_q == BB'(b)) rd_mux = bank_rdata[b];
    end
  end

  // Transfer control: decode in IDLE, count read waits, pulse ack/err once.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q  <= IDLE;
      wait_q   <= '0;
      bank_q   <= '0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (valid) begin
            if (!in_range) begin
              wb_err_o <= 1'b1;
              state_q  <= ERR;
            end else if (wb_we_i) begin
              wb_ack_o <= 1'b1;
              state_q  <= ACK;
            end else begin
              bank_q  <= bank_idx;
              wait_q  <= 2'(READ_WAIT);
              state_q <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (!wb_cyc_i) begin
            state_q <= IDLE;
          end else if (wait_q == 2'd0) begin
            wb_dat_o <= rd_mux;
            wb_ack_o <= 1'b1;
            state_q  <= ACK;
          end else begin
            wait_q <= wait_q - 2'd1;
          end
        end
        ACK:     state_q <= IDLE;
        ERR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_wb_banked.md
Name: mem_wb_banked

Overview:
- Parametrised Wishbone classic slave SRAM. Successor to the fixed two-bank, 1024-word user-area memory.
- Generalises to NUM_BANKS banks of WORDS_PER_BANK 32-bit words, with configurable read wait states.
- Registers the read-bank select, signals out-of-range accesses on err_o, and supports cycle abort.
- Sits on the user-project Wishbone bus as a scratch or data RAM; banks are behavioural arrays, or macros swapped in per bank.

Parameters:
NUM_BANKS, 2, number of banks; 1..8
WORDS_PER_BANK, 512, 32-bit words per bank; power of two, 16..4096
READ_WAIT, 0, extra wait cycles inserted before read ack; 0..3
BASE_MASK_BITS, 0, reserved; must be 0 (address bits above the decoded range are ignored)

Ports:
wb_clk_i  in  1  bus clock; the only clock
wb_rst_n_i  in  1  asynchronous active-low reset
wb_adr_i  in  32  byte address
wb_dat_i  in  32  write data
wb_sel_i  in  4  byte lane selects
wb_we_i  in  1  write enable
wb_cyc_i  in  1  bus cycle
wb_stb_i  in  1  strobe
wb_ack_o  out  1  transfer acknowledge
wb_err_o  out  1  out-of-range acknowledge
wb_dat_o  out  32  registered read data

Behaviour:
- Clocking and reset: one clock, wb_clk_i. Reset is asynchronous and active-low on wb_rst_n_i.
- Reset values: wb_ack_o=0, wb_err_o=0, wb_dat_o=0, FSM=IDLE. Memory contents are not cleared.
- Address decode:
  - WB = log2(WORDS_PER_BANK); word index = wb_adr_i[WB+1:2].
  - Bank index = wb_adr_i[WB+1+BB:WB+2], where BB = max(1, ceil(log2(NUM_BANKS))).
  - wb_adr_i[1:0] and higher bits are ignored (aliasing).
  - Bank index >= NUM_BANKS is out of range.
- valid = wb_cyc_i & wb_stb_i.
- FSM states: IDLE, RD_WAIT, ACK, ERR.
- IDLE transitions:
  - valid & out of range: go to ERR. No bank is enabled.
  - valid & we: write the selected bank at this edge, lanes gated by wb_sel_i. Go to ACK.
  - valid & ~we: enable only the selected bank for read, capture bank index into a register. Go to RD_WAIT, loaded with READ_WAIT.
- RD_WAIT:
  - Bank data is available one cycle after enable. Count down the wait cycles.
  - When the count reaches 0, load wb_dat_o from the bank chosen by the registered index (never the live address), then go to ACK.
  - If wb_cyc_i drops, go to IDLE: no ack, wb_dat_o unchanged.
- ACK: wb_ack_o=1 for exactly one cycle, then IDLE. valid is ignored in this cycle.
- ERR: wb_err_o=1 for exactly one cycle, then IDLE. wb_dat_o unchanged.
- Latency from stb to ack:
  - Write: ack visible at cycle 1 (registered).
  - Read: ack at cycle 2+READ_WAIT, with data valid in the same cycle as ack.
- Throughput: minimum spacing between transfers is 2 cycles (write) and 3+READ_WAIT cycles (read).
- Data hold: wb_dat_o holds its value until the next completed read. wb_ack_o and wb_err_o are never high together.
- wb_sel_i=0 on a write: no memory change, ack still issued.
- Reset asserted mid-operation: outputs clear immediately (async). A write already clocked is kept; a pending read is dropped.
- Unselected banks: chip-enable stays inactive every cycle.
- Each bank has one R/W port. The unused port of a dual-port macro is tied inactive.

Test Plan:
- Reset, then write 0xDEADBEEF sel=4'hF to 0x000 and read it back -> write ack at cycle 1; read ack at cycle 2 with wb_dat_o=0xDEADBEEF.
- Byte lanes: write 0x11223344 sel=F to 0x804 (bank1, word1), then 0xAABBCCDD sel=4'b0101 -> read returns 0x11BB33DD; bank0 word1 unchanged.
- NUM_BANKS=3, WORDS_PER_BANK=512:
  - Read 0x1800 (bank3) -> wb_err_o pulses one cycle at cycle 1, no ack, wb_dat_o unchanged.
  - Read 0x1000 (bank2) -> normal ack.
- READ_WAIT=2: read 0x004 -> ack at cycle 4. Dropping cyc at cycle 2 on a second read -> no ack, FSM returns to IDLE, wb_dat_o keeps the old value.
- Address changes after the read issue cycle (bank0 -> bank1 while in RD_WAIT) -> returned data is from bank0.
- Assert wb_rst_n_i low asynchronously during a read wait -> ack, err and wb_dat_o go to 0 without a clock edge. A post-reset read of previously written data still returns that data.
